// File: rtl/uart_pkg.sv
// Shared UART constants: clock dividers, data width, default RX FIFO depth
// and the idle-timeout length derived from the baud divider.
package uart_pkg;

  localparam int unsigned BAUD_DIV        = 434;  // 50 MHz / 115200
  localparam int unsigned TICK_DIV        = 27;   // 16x oversample tick
  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // Four character times of 10 bits each (start + 8 data + stop).
  localparam int unsigned UART_TIMEOUT_CYCLES = 4 * 10 * BAUD_DIV;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream into the RX FIFO and valid/ready stream out of it.
// slave: FIFO side. master: receiver/consumer side.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] in_data;
  logic                   in_valid;
  logic [UART_DATA_W-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

endinterface

// File: rtl/uart_idle_timer.sv
// Saturating idle counter for the RX FIFO. Clears on an accepted push or
// while the FIFO is (about to be) empty; flags timeout once it saturates.
module uart_idle_timer
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,       // byte accepted this cycle
  input  logic empty_nxt_i,  // FIFO empty after this edge
  output logic timeout_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  // Next count and timeout flag, computed from next-state FIFO status so the
  // flag falls in the cycle right after a push or drain.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i || empty_nxt_i)
      cnt_d = '0;
    else if (cnt_q != LIMIT)
      cnt_d = cnt_q + 16'd1;
    timeout_d = (cnt_d == LIMIT) && !empty_nxt_i;
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT FIFO fed by one-cycle byte strobes, drained over
// valid/ready. Registered level/full/empty, sticky overflow.
// Optional idle timeout: define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = UART_FIFO_DEPTH,
  parameter int unsigned ADDR_W         = $clog2(DEPTH),
  parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_fifo_if.slave     bus,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              rx_timeout
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop, drop;

  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign pop     = !empty_q && bus.out_ready;
  assign push_ok = bus.in_valid && (!full_q || pop);
  assign drop    = bus.in_valid && full_q && !pop;

  // Next-state pointers, level, status and sticky overflow (set beats clear).
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop)
      level_d = level_q + (ADDR_W+1)'(1);
    else if (pop && !push_ok)
      level_d = level_q - (ADDR_W+1)'(1);
    full_d     = (level_d == (ADDR_W+1)'(DEPTH));
    empty_d    = (level_d == '0);
    overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_q] <= bus.in_data;
  end

  assign bus.out_data  = mem[rd_ptr_q];
  assign bus.out_valid = !empty_q;
  assign level         = level_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign overflow      = overflow_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  uart_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_ok),
    .empty_nxt_i (empty_d),
    .timeout_o   (rx_timeout)
  );
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, TIMEOUT_CYCLES=100).
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] level;
  logic       full, empty, overflow, clr_overflow, rx_timeout;
  int         total = 0;
  int         bad   = 0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .rx_timeout   (rx_timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; clr_overflow = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
    total++; if (overflow !== 1'b0 || rx_timeout !== 1'b0) begin bad++; $display("FAIL reset_ovf_to ovf=%b to=%b exp 0/0", overflow, rx_timeout); end
  endtask

  task automatic test_basic();
    push(8'h41); push(8'h42); push(8'h43);
    total++; if (level !== 5'd3) begin bad++; $display("FAIL basic_level got=%0d exp=3", level); end
    total++; if (bus.out_data !== 8'h41 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_head got=%h v=%b exp=41 v=1", bus.out_data, bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.out_data !== 8'(8'h41 + i)) begin bad++; $display("FAIL basic_read%0d got=%h exp=%h", i, bus.out_data, 8'(8'h41 + i)); end
      tick();
    end
    bus.out_ready = 1'b0;
    total++; if (empty !== 1'b1 || level !== 5'd0) begin bad++; $display("FAIL basic_drained empty=%b level=%0d exp 1/0", empty, level); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push(8'(i));
    total++; if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_full full=%b ovf=%b exp 1/0", full, overflow); end
    push(8'h10);
    total++; if (overflow !== 1'b1 || level !== 5'd16) begin bad++; $display("FAIL ovf_set ovf=%b level=%0d exp 1/16", overflow, level); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.out_data !== 8'(i)) begin bad++; $display("FAIL ovf_read%0d got=%h exp=%h", i, bus.out_data, 8'(i)); end
      tick();
    end
    bus.out_ready = 1'b0;
    total++; if (empty !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky empty=%b ovf=%b exp 1/1", empty, overflow); end
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
    bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++; if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL fpp_status level=%0d full=%b ovf=%b exp 16/1/0", level, full, overflow); end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      total++; if (bus.out_data !== 8'(8'h50 + i)) begin bad++; $display("FAIL fpp_read%0d got=%h exp=%h", i, bus.out_data, 8'(8'h50 + i)); end
      tick();
    end
    total++; if (bus.out_data !== 8'hAA || level !== 5'd1) begin bad++; $display("FAIL fpp_last got=%h level=%0d exp AA/1", bus.out_data, level); end
    tick();
    bus.out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.out_data !== 8'(8'h10 + i)) begin bad++; $display("FAIL wrap_a%0d got=%h exp=%h", i, bus.out_data, 8'(8'h10 + i)); end
      tick();
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
    total++; if (level !== 5'd10) begin bad++; $display("FAIL wrap_level got=%0d exp=10", level); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.out_data !== 8'(8'h80 + i)) begin bad++; $display("FAIL wrap_b%0d got=%h exp=%h", i, bus.out_data, 8'(8'h80 + i)); end
      tick();
    end
    bus.out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    total++; if (level !== 5'd5) begin bad++; $display("FAIL rmid_pre level=%0d exp=5", level); end
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin bad++; $display("FAIL rmid_async v=%b level=%0d ovf=%b exp 0/0/0", bus.out_valid, level, overflow); end
    tick();
    rst = 1'b0;
    tick();
    push(8'h5A);
    total++; if (bus.out_data !== 8'h5A || level !== 5'd1) begin bad++; $display("FAIL rmid_after got=%h level=%0d exp 5A/1", bus.out_data, level); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    push(8'h77);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    for (int k = 1; k < 101; k++) begin
      if (k == 1 || k == 100) begin
        total++; if (rx_timeout !== 1'b0) begin bad++; $display("FAIL to_early cyc=%0d got=%b exp=0", k, rx_timeout); end
      end
      tick();
    end
    total++; if (rx_timeout !== 1'b1) begin bad++; $display("FAIL to_rise got=%b exp=1", rx_timeout); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    total++; if (rx_timeout !== 1'b0) begin bad++; $display("FAIL to_drain got=%b exp=0", rx_timeout); end
`else
    for (int k = 1; k < 151; k++) begin
      total++; if (rx_timeout !== 1'b0) begin bad++; $display("FAIL to_off cyc=%0d got=%b exp=0", k, rx_timeout); end
      tick();
    end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
